// File: rtl/weight_pingpong_buffer_pkg.sv
// weight_pingpong_buffer_pkg: shared widths and fill FSM encoding for the weight ping-pong buffer
package weight_pingpong_buffer_pkg;
   localparam int DATA_W_DEF = 128;
   localparam int CNT_W = 17;
   typedef enum logic [1:0] {F_IDLE, F_REQ, F_FILL} fill_state_e;
endpackage

// File: rtl/weight_bank_ram.sv
// weight_bank_ram: simple dual-port bank storage, one write port and one registered read port
module weight_bank_ram
   import weight_pingpong_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int AW = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: loads weight jobs from an arbiter channel into two alternating banks for the PE array
module weight_pingpong_buffer
   import weight_pingpong_buffer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [ADDR_W-1:0]  cfg_base,
   input  logic [CNT_W-1:0]   cfg_count,
   output logic               ldr_req,
   output logic [ADDR_W-1:0]  ldr_base,
   output logic [CNT_W-1:0]   ldr_count,
   input  logic               ldr_grant,
   input  logic               ldr_valid,
   input  logic [DATA_W-1:0]  ldr_data,
   input  logic               ldr_done,
   output logic               wb_ready,
   output logic [DEPTH_W:0]   wb_len,
   input  logic               wb_rd_en,
   input  logic [DEPTH_W-1:0] wb_rd_addr,
   output logic [DATA_W-1:0]  wb_rd_data,
   input  logic               wb_release,
   output logic               err_overflow
);
   fill_state_e state, state_n;
   logic fill_sel, fill_n, rd_sel, rd_n, grant_q, ovf_n, wr_ok;
   logic [1:0] bank_full, full_n;
   logic [1:0][DEPTH_W:0] bank_len, len_n;
   logic [DEPTH_W:0] wr_ptr, ptr_n;
   logic [ADDR_W-1:0] base_n;
   logic [CNT_W-1:0] count_n;
   // wr_ptr saturates at 2^DEPTH_W, so its top bit marks a full bank
   assign wr_ok = !wr_ptr[DEPTH_W];
   assign wb_ready = bank_full[rd_sel];
   assign wb_len = bank_len[rd_sel];
   always_comb begin
      state_n = state;
      fill_n = fill_sel;
      rd_n = rd_sel;
      full_n = bank_full;
      len_n = bank_len;
      ptr_n = wr_ptr;
      base_n = ldr_base;
      count_n = ldr_count;
      ovf_n = err_overflow;
      if (wb_release && bank_full[rd_sel]) begin
         full_n[rd_sel] = 1'b0;
         rd_n = !rd_sel;
      end
      case (state)
         F_IDLE:
            if (cfg_valid && cfg_ready) begin
               base_n = cfg_base;
               count_n = cfg_count;
               ptr_n = '0;
               if (cfg_count == '0) begin
                  full_n[fill_sel] = 1'b1;
                  len_n[fill_sel] = '0;
                  fill_n = !fill_sel;
               end else state_n = F_REQ;
            end
         F_REQ: state_n = (ldr_grant && !grant_q) ? F_FILL : F_REQ;
         F_FILL: begin
            if (ldr_valid && wr_ok) ptr_n = wr_ptr + (DEPTH_W+1)'(1);
            if (ldr_valid && !wr_ok) ovf_n = 1'b1;
            if (ldr_done) begin
               full_n[fill_sel] = 1'b1;
               len_n[fill_sel] = ptr_n;
               fill_n = !fill_sel;
               state_n = F_IDLE;
            end
         end
         default: state_n = F_IDLE;
      endcase
   end
   // grant_q resets high so a grant left asserted across reset never looks like a fresh edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= F_IDLE;
         fill_sel <= 1'b0;
         rd_sel <= 1'b0;
         bank_full <= '0;
         bank_len <= '0;
         wr_ptr <= '0;
         ldr_base <= '0;
         ldr_count <= '0;
         err_overflow <= 1'b0;
         grant_q <= 1'b1;
         cfg_ready <= 1'b0;
         ldr_req <= 1'b0;
      end else begin
         state <= state_n;
         fill_sel <= fill_n;
         rd_sel <= rd_n;
         bank_full <= full_n;
         bank_len <= len_n;
         wr_ptr <= ptr_n;
         ldr_base <= base_n;
         ldr_count <= count_n;
         err_overflow <= ovf_n;
         grant_q <= ldr_grant;
         cfg_ready <= state_n == F_IDLE && !full_n[fill_n];
         ldr_req <= state_n == F_REQ;
      end
   weight_bank_ram #(.DATA_W(DATA_W), .AW(DEPTH_W+1)) u_ram (
      .clk(clk),
      .rst(rst),
      .we(state == F_FILL && ldr_valid && wr_ok),
      .waddr({fill_sel, wr_ptr[DEPTH_W-1:0]}),
      .wdata(ldr_data),
      .re(wb_rd_en),
      .raddr({rd_sel, wb_rd_addr}),
      .rdata(wb_rd_data)
   );
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb_weight_pingpong_buffer: directed self-checking bench for the weight ping-pong buffer
module tb_weight_pingpong_buffer;
   logic clk = 0, rst = 1;
   logic cfg_valid = 0, cfg_ready;
   logic [31:0] cfg_base = 0, ldr_base;
   logic [16:0] cfg_count = 0, ldr_count;
   logic ldr_req, ldr_grant = 0, ldr_valid = 0, ldr_done = 0;
   logic [127:0] ldr_data = 0, wb_rd_data;
   logic wb_ready, wb_rd_en = 0, wb_release = 0, err_overflow;
   logic [6:0] wb_len;
   logic [5:0] wb_rd_addr = 0;
   int checks = 0, failures = 0;

   weight_pingpong_buffer dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_base(cfg_base), .cfg_count(cfg_count), .ldr_req(ldr_req),
      .ldr_base(ldr_base), .ldr_count(ldr_count), .ldr_grant(ldr_grant),
      .ldr_valid(ldr_valid), .ldr_data(ldr_data), .ldr_done(ldr_done),
      .wb_ready(wb_ready), .wb_len(wb_len), .wb_rd_en(wb_rd_en),
      .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
      .wb_release(wb_release), .err_overflow(err_overflow)
   );

   always #5 clk = !clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [16:0] cnt, input logic [31:0] base);
      int n = 0;
      while (!cfg_ready && n < 20) begin
         tick;
         n++;
      end
      chk("cfg_ready_wait", cfg_ready, 1);
      cfg_valid = 1;
      cfg_count = cnt;
      cfg_base = base;
      tick;
      cfg_valid = 0;
   endtask

   task automatic grant_after(input int d);
      repeat (d) tick;
      ldr_grant = 1;
      tick;
   endtask

   task automatic stream(input int n, input logic [127:0] first, input logic rel);
      for (int i = 0; i < n; i++) begin
         ldr_valid = 1;
         ldr_data = first + 128'(i);
         tick;
      end
      ldr_valid = 0;
      ldr_done = 1;
      wb_release = rel;
      tick;
      ldr_done = 0;
      wb_release = 0;
      ldr_grant = 0;
   endtask

   task automatic rd(input logic [5:0] a);
      wb_rd_addr = a;
      wb_rd_en = 1;
      tick;
      wb_rd_en = 0;
   endtask

   task automatic release_bank;
      wb_release = 1;
      tick;
      wb_release = 0;
   endtask

   initial begin
      tick;
      tick;
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_ldr_req", ldr_req, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_wb_len", wb_len, 0);
      chk("rst_rd_data", wb_rd_data, 0);
      chk("rst_ovf", err_overflow, 0);
      rst = 0;
      tick;
      chk("idle_cfg_ready", cfg_ready, 1);

      // single job of 4 words into bank 0
      start_job(4, 32'h1000);
      chk("s_req", ldr_req, 1);
      chk("s_base", ldr_base, 32'h1000);
      chk("s_count", ldr_count, 4);
      chk("s_busy", cfg_ready, 0);
      grant_after(2);
      chk("s_req_drop", ldr_req, 0);
      stream(4, 1, 0);
      chk("s_ready", wb_ready, 1);
      chk("s_len", wb_len, 4);
      rd(2);
      chk("s_rd2", wb_rd_data, 3);
      wb_rd_addr = 0;
      tick;
      chk("s_hold", wb_rd_data, 3);
      release_bank;
      chk("s_released", wb_ready, 0);

      // ping-pong: A (3) into bank 1, B (5) into bank 0
      start_job(3, 32'h2000);
      grant_after(1);
      stream(3, 128'h10, 0);
      start_job(5, 32'h3000);
      grant_after(1);
      stream(5, 128'h20, 0);
      chk("pp_block", cfg_ready, 0);
      chk("pp_lenA", wb_len, 3);
      rd(0);
      chk("pp_rdA", wb_rd_data, 128'h10);
      cfg_valid = 1;
      cfg_count = 2;
      tick;
      tick;
      chk("pp_c_blocked_req", ldr_req, 0);
      chk("pp_c_blocked_rdy", cfg_ready, 0);
      cfg_valid = 0;
      release_bank;
      chk("pp_c_free", cfg_ready, 1);
      chk("pp_lenB", wb_len, 5);
      rd(4);
      chk("pp_rdB", wb_rd_data, 128'h24);
      release_bank;
      chk("pp_empty", wb_ready, 0);

      // overflow: 70 words into bank 1
      start_job(70, 32'h4000);
      grant_after(1);
      stream(70, 128'h100, 0);
      chk("ov_flag", err_overflow, 1);
      chk("ov_len", wb_len, 64);
      rd(63);
      chk("ov_w63", wb_rd_data, 128'h13f);
      rd(0);
      chk("ov_w0", wb_rd_data, 128'h100);
      release_bank;

      // zero-count job into bank 0
      start_job(0, 32'h5000);
      chk("z_noreq", ldr_req, 0);
      chk("z_ready", wb_ready, 1);
      chk("z_len", wb_len, 0);
      release_bank;

      // reset mid-fill with grant held high
      start_job(4, 32'h6000);
      grant_after(1);
      ldr_valid = 1;
      ldr_data = 128'hAA;
      tick;
      tick;
      ldr_valid = 0;
      rst = 1;
      #1;
      chk("mr_rst_ovf", err_overflow, 0);
      chk("mr_rst_req", ldr_req, 0);
      chk("mr_rst_rdy", cfg_ready, 0);
      tick;
      rst = 0;
      ldr_valid = 1;
      ldr_done = 1;
      ldr_data = 128'hDEAD;
      tick;
      ldr_valid = 0;
      ldr_done = 0;
      chk("mr_stray", wb_ready, 0);
      start_job(2, 32'h7000);
      tick;
      tick;
      chk("mr_wait_high", ldr_req, 1);
      ldr_grant = 0;
      tick;
      chk("mr_wait_low", ldr_req, 1);
      ldr_grant = 1;
      tick;
      chk("mr_granted", ldr_req, 0);
      stream(2, 128'h55, 0);
      chk("mr_ready", wb_ready, 1);
      chk("mr_len", wb_len, 2);
      rd(1);
      chk("mr_rd1", wb_rd_data, 128'h56);

      // release bank 0 in the same cycle bank 1 completes
      start_job(3, 32'h8000);
      grant_after(1);
      stream(3, 128'h70, 1);
      chk("sc_ready", wb_ready, 1);
      chk("sc_len", wb_len, 3);
      chk("sc_cfg_ready", cfg_ready, 1);
      rd(2);
      chk("sc_rd2", wb_rd_data, 128'h72);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
